// File: rtl/bcd_scan_collector.sv
// Receive side of a multiplexed BCD digit scan: rebuilds tens*10+units from the
// scanned units/tens/marker digits and flags malformed frames.
module bcd_scan_collector #(
  parameter int VAL_W   = 5,
  parameter int MAX_VAL = 31
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic [3:0]       BCD,
  input  logic [3:0]       sel_an,
  output logic [VAL_W-1:0] value,
  output logic             mark,
  output logic             valid,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {IDLE, GOT_U, GOT_T, GOT_A} state_t;

  localparam logic [3:0] SEL_U  = 4'b1110;
  localparam logic [3:0] SEL_T  = 4'b1101;
  localparam logic [3:0] SEL_A  = 4'b1011;
  localparam logic [7:0] MAX_V8 = 8'(MAX_VAL);

  state_t           state_q, state_d;
  logic [3:0]       units_q, units_d, tens_q, tens_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             mark_q, mark_d, valid_q, valid_d, err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic       is_u, is_t, is_a, digit_ok;
  logic       do_commit, commit_mark, start_u, bad, seq, range_err;
  logic [7:0] commit_val;

  assign is_u       = (sel_an == SEL_U);
  assign is_t       = (sel_an == SEL_T);
  assign is_a       = (sel_an == SEL_A);
  assign digit_ok   = (BCD <= 4'd9);
  // Range check happens on the full 8-bit sum, before truncation to VAL_W.
  assign commit_val = {4'b0, tens_q} * 8'd10 + {4'b0, units_q};

  always_comb begin
    state_d     = state_q;
    units_d     = units_q;
    tens_d      = tens_q;
    value_d     = value_q;
    mark_d      = mark_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    do_commit   = 1'b0;
    commit_mark = 1'b0;
    start_u     = 1'b0;
    bad         = 1'b0;
    seq         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (is_u) begin
          if (digit_ok) start_u = 1'b1;
          else          bad     = 1'b1;
        end
      end
      GOT_U: begin
        if (is_t && digit_ok)            begin tens_d = BCD; state_d = GOT_T; end
        else if ((is_u || is_t) && !digit_ok) bad = 1'b1;
        else                             seq = 1'b1;
      end
      GOT_T: begin
        if (is_u) begin
          do_commit = 1'b1;
          if (digit_ok) start_u = 1'b1;
          else          bad     = 1'b1;
        end else if (is_a) begin
          if (BCD == 4'hA) state_d = GOT_A;
          else             bad     = 1'b1;
        end else if (is_t && !digit_ok) bad = 1'b1;
        else                            seq = 1'b1;
      end
      GOT_A: begin
        if (is_u) begin
          do_commit   = 1'b1;
          commit_mark = 1'b1;
          if (digit_ok) start_u = 1'b1;
          else          bad     = 1'b1;
        end else if (is_t && !digit_ok) bad = 1'b1;
        else                            seq = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // An out-of-order 1110 with a good digit still opens a fresh frame.
    if (seq && is_u) start_u = 1'b1;

    range_err = do_commit && (commit_val > MAX_V8);

    if (do_commit && !range_err) begin
      value_d = commit_val[VAL_W-1:0];
      mark_d  = commit_mark;
      valid_d = 1'b1;
    end

    if (bad || seq || range_err) begin
      err_d      = 1'b1;
      err_code_d = bad ? 2'b01 : (seq ? 2'b10 : 2'b11);
    end

    if (start_u) begin
      units_d = BCD;
      state_d = GOT_U;
    end else if (bad || seq) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q    <= IDLE;
      units_q    <= '0;
      tens_q     <= '0;
      value_q    <= '0;
      mark_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      value_q    <= value_d;
      mark_q     <= mark_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign value    = value_q;
  assign mark     = mark_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
